fp_round_pack: RTL and testbench

Final stage of the single-precision IEEE-754 adder/subtractor datapath, directly downstream of the normaliser. It takes the normalised 24-bit significand, the signed normalisation shift count and the pre-normalisation exponent. It then applies round-to-nearest-even, re-normalises on rounding carry, detects overflow and underflow, and packs a 32-bit IEEE result. It is a 2-stage valid/ready pipeline with full-throughput backpressure support. Subnormals are flushed to zero.

---
 rtl/fp_pkg.sv | 17 +
 rtl/fp_round_rne.sv | 24 ++
 rtl/fp_round_pack.sv | 207 ++++++++++++++++++++
 tb/tb_fp_round_pack.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point datapath definitions for the single-precision
// adder/subtractor (normaliser, round/pack) and the multiplier path.
package fp_pkg;

    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    // Guard, round and sticky bits left over below the significand LSB.
    typedef struct packed {
        logic g;
        logic r;
        logic s;
    } grs_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even increment of a significand using its guard,
// round and sticky bits. Purely combinational so the multiplier path
// can reuse it. mant_r carries one extra bit for the rounding carry.
module fp_round_rne
    import fp_pkg::*;
#(
    parameter int SIG_W = fp_pkg::MAN_W + 1
) (
    input  logic [SIG_W-1:0] mant,
    input  grs_t             grs,
    output logic [SIG_W:0]   mant_r,
    output logic             inexact
);

    logic round_up_s;

    // Round up above the halfway point, or exactly at it when the LSB is odd.
    always_comb begin
        round_up_s = grs.g & (grs.r | grs.s | mant[0]);
        mant_r     = {1'b0, mant} + {{SIG_W{1'b0}}, round_up_s};
        inexact    = grs.g | grs.r | grs.s;
    end

endmodule

// File: rtl/fp_round_pack.sv
// Final stage of the single-precision add/sub datapath: rounds the
// normalised significand (RNE), fixes up a rounding carry, saturates to
// +/-Inf on overflow, flushes to +/-0 on underflow and packs the IEEE word.
// Two-stage valid/ready pipeline: s1 rounds, s2 fixes, packs and holds the
// output registers. Both stages may be full, so the block keeps full
// throughput under backpressure.
module fp_round_pack #(
    parameter int EXP_W = fp_pkg::EXP_W,
    parameter int MAN_W = fp_pkg::MAN_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   sign_in,
    input  logic [EXP_W-1:0]       exp_in,
    input  logic signed [7:0]      incr,
    input  logic [MAN_W:0]         mant_in,
    input  logic [2:0]             grs_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   inexact
);

    import fp_pkg::*;

    localparam int SIG_W = MAN_W + 1;
    localparam int EW    = EXP_W + 2;           // signed headroom for the shift
    localparam int RES_W = 1 + EXP_W + MAN_W;

    localparam logic signed [EW-1:0] EXP_SAT  = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
    localparam logic signed [EW-1:0] EXP_ZERO = EW'(0);

    // Handshake enables
    logic s2_adv_s;
    logic s1_adv_s;

    // Rounding of the incoming operand
    logic [SIG_W:0]        mant_r_s;
    logic                  rnd_inexact_s;
    logic signed [EW-1:0]  exp_adj_s;

    // Stage 1 state
    logic                  s1_valid_q,   s1_valid_d;
    logic                  s1_sign_q,    s1_sign_d;
    logic signed [EW-1:0]  s1_exp_adj_q, s1_exp_adj_d;
    logic [SIG_W:0]        s1_mant_r_q,  s1_mant_r_d;
    logic                  s1_is_zero_q, s1_is_zero_d;
    logic                  s1_inexact_q, s1_inexact_d;

    // Fix-up and pack of the stage-1 contents
    logic [MAN_W-1:0]      mant_f_s;
    logic signed [EW-1:0]  exp_f_s;
    logic [RES_W-1:0]      pk_result_s;
    logic                  pk_overflow_s;
    logic                  pk_underflow_s;
    logic                  pk_inexact_s;

    // Stage 2 (output) state
    logic                  out_valid_q,  out_valid_d;
    logic [RES_W-1:0]      result_q,     result_d;
    logic                  overflow_q,   overflow_d;
    logic                  underflow_q,  underflow_d;
    logic                  inexact_q,    inexact_d;

    fp_round_rne #(
        .SIG_W (SIG_W)
    ) u_rne (
        .mant    (mant_in),
        .grs     (grs_t'(grs_in)),
        .mant_r  (mant_r_s),
        .inexact (rnd_inexact_s)
    );

    // Pipeline enables; in_ready depends on out_ready and state, never on in_valid.
    always_comb begin
        s2_adv_s = !out_valid_q | out_ready;
        s1_adv_s = !s1_valid_q | s2_adv_s;
    end

    // Exponent after the normaliser shift, widened so it can go negative or past the max.
    always_comb begin
        exp_adj_s = $signed({2'b00, exp_in}) + $signed({{(EW-8){incr[7]}}, incr});
    end

    // Stage-1 next state: capture a new operand whenever the stage can move.
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_sign_d    = s1_sign_q;
        s1_exp_adj_d = s1_exp_adj_q;
        s1_mant_r_d  = s1_mant_r_q;
        s1_is_zero_d = s1_is_zero_q;
        s1_inexact_d = s1_inexact_q;
        if (s1_adv_s) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sign_d    = sign_in;
                s1_exp_adj_d = exp_adj_s;
                s1_mant_r_d  = mant_r_s;
                s1_is_zero_d = (mant_in == {SIG_W{1'b0}});
                s1_inexact_d = rnd_inexact_s;
            end else begin
                s1_is_zero_d = s1_is_zero_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Rounding-carry fix-up, then zero / overflow / underflow / normal packing in priority order.
    always_comb begin
        if (s1_mant_r_q[SIG_W]) begin
            mant_f_s = s1_mant_r_q[MAN_W:1];
            exp_f_s  = s1_exp_adj_q + EXP_ONE;
        end else begin
            mant_f_s = s1_mant_r_q[MAN_W-1:0];
            exp_f_s  = s1_exp_adj_q;
        end

        pk_result_s    = {RES_W{1'b0}};
        pk_overflow_s  = 1'b0;
        pk_underflow_s = 1'b0;
        pk_inexact_s   = 1'b0;
        if (s1_is_zero_q) begin
            // Exact cancellation always yields +0.
            pk_result_s = {RES_W{1'b0}};
        end else if (exp_f_s >= EXP_SAT) begin
            pk_result_s   = {s1_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            pk_overflow_s = 1'b1;
            pk_inexact_s  = 1'b1;
        end else if (exp_f_s <= EXP_ZERO) begin
            // Subnormal range is flushed to a signed zero.
            pk_result_s    = {s1_sign_q, {(RES_W-1){1'b0}}};
            pk_underflow_s = 1'b1;
            pk_inexact_s   = 1'b1;
        end else begin
            pk_result_s  = {s1_sign_q, exp_f_s[EXP_W-1:0], mant_f_s};
            pk_inexact_s = s1_inexact_q;
        end
    end

    // Stage-2 next state: load the packed word when the output slot frees up, else hold.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        inexact_d   = inexact_q;
        if (s2_adv_s) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d    = pk_result_s;
                overflow_d  = pk_overflow_s;
                underflow_d = pk_underflow_s;
                inexact_d   = pk_inexact_s;
            end else begin
                result_d    = result_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Pipeline registers; async reset drops every in-flight item at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_exp_adj_q <= EXP_ZERO;
            s1_mant_r_q  <= {(SIG_W+1){1'b0}};
            s1_is_zero_q <= 1'b0;
            s1_inexact_q <= 1'b0;
            out_valid_q  <= 1'b0;
            result_q     <= {RES_W{1'b0}};
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            inexact_q    <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_sign_q    <= s1_sign_d;
            s1_exp_adj_q <= s1_exp_adj_d;
            s1_mant_r_q  <= s1_mant_r_d;
            s1_is_zero_q <= s1_is_zero_d;
            s1_inexact_q <= s1_inexact_d;
            out_valid_q  <= out_valid_d;
            result_q     <= result_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            inexact_q    <= inexact_d;
        end
    end

    // Registered outputs and the combinational ready.
    always_comb begin
        in_ready  = s1_adv_s;
        out_valid = out_valid_q;
        result    = result_q;
        overflow  = overflow_q;
        underflow = underflow_q;
        inexact   = inexact_q;
    end

endmodule

// File: tb/tb_fp_round_pack.sv
// Self-checking bench for fp_round_pack: directed vectors with fixed
// expected words, backpressure and mid-stream reset sequences, and a
// randomized stream scored against a value-level rounding model.
module tb_fp_round_pack;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic              sign_in;
    logic [7:0]        exp_in;
    logic signed [7:0] incr;
    logic [23:0]       mant_in;
    logic [2:0]        grs_in;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       result;
    logic              overflow;
    logic              underflow;
    logic              inexact;

    int n_cmp = 0;
    int n_err = 0;
    int n_pop = 0;
    bit mon_en = 1'b0;
    logic [34:0] exp_q[$];

    fp_round_pack dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign_in   (sign_in),
        .exp_in    (exp_in),
        .incr      (incr),
        .mant_in   (mant_in),
        .grs_in    (grs_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .inexact   (inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              sign;
        logic [7:0]        exp;
        logic signed [7:0] inc;
        logic [23:0]       mant;
        logic [2:0]        grs;
        logic [31:0]       res;
        logic              ov;
        logic              uf;
        logic              ix;
    } vec_t;

    vec_t vecs[11];
    vec_t bp[4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, expv);
        end
    endtask

    // Value-level model: treat {mant,grs} as a fixed-point number with three
    // fraction bits, round it to the nearest integer (ties to even), renormalise.
    function automatic logic [34:0] ref_model(input logic s, input logic [7:0] e,
                                              input logic signed [7:0] inc,
                                              input logic [23:0] m, input logic [2:0] g);
        int     ex;
        longint full;
        longint q;
        int     rem;
        if (m == 24'd0) return 35'd0;
        ex   = int'(e) + int'(inc);
        full = (longint'(m) << 3) | longint'(g);
        q    = full >> 3;
        rem  = int'(full % 8);
        if (rem > 4 || (rem == 4 && (q % 2) == 1)) q = q + 1;
        if (q >= 64'h1000000) begin
            q  = q / 2;
            ex = ex + 1;
        end
        if (ex >= 255) return {s, 8'hFF, 23'd0, 1'b1, 1'b0, 1'b1};
        if (ex <= 0)   return {s, 31'd0, 1'b0, 1'b1, 1'b1};
        return {s, 8'(ex), 23'(q), 1'b0, 1'b0, (g != 3'd0)};
    endfunction

    task automatic drive(input vec_t v);
        sign_in = v.sign;
        exp_in  = v.exp;
        incr    = v.inc;
        mant_in = v.mant;
        grs_in  = v.grs;
    endtask

    // One isolated item: ready on entry, invisible after one edge, visible after two.
    task automatic apply_vec(input vec_t v, input string nm);
        @(posedge clk); #1;
        drive(v);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk({nm, ".in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk({nm, ".lat1_valid"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        chk({nm, ".lat2_valid"}, 64'(out_valid), 64'd1);
        chk({nm, ".result"},    64'(result),    64'(v.res));
        chk({nm, ".overflow"},  64'(overflow),  64'(v.ov));
        chk({nm, ".underflow"}, 64'(underflow), 64'(v.uf));
        chk({nm, ".inexact"},   64'(inexact),   64'(v.ix));
    endtask

    // Scoreboard: record expectations on input handshakes, compare on output handshakes.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected", 64'(result), 64'd0);
                    n_err += (result == 32'd0) ? 1 : 0;
                end else begin
                    chk("sb_item", 64'({result, overflow, underflow, inexact}), 64'(exp_q.pop_front()));
                end
                n_pop++;
            end
            if (in_valid && in_ready)
                exp_q.push_back(ref_model(sign_in, exp_in, incr, mant_in, grs_in));
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        int   idx;
        int   stall;
        int   base;
        int   t;
        vec_t rv;
        logic [34:0] e0;

        //            sign exp    inc    mant       grs     result        ov    uf    ix
        vecs[0]  = '{1'b0, 8'd127, 8'sd0,  24'h800000, 3'b000, 32'h3F800000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'd127, 8'sd0,  24'hFFFFFF, 3'b100, 32'h40000000, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 8'd127, 8'sd0,  24'hFFFFFE, 3'b100, 32'h3FFFFFFE, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 8'd254, 8'sd1,  24'h800000, 3'b000, 32'hFF800000, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 8'd1,   -8'sd5, 24'h800000, 3'b000, 32'h00000000, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{1'b1, 8'd100, -8'sd24,24'h000000, 3'b000, 32'h00000000, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 8'd254, 8'sd0,  24'hFFFFFF, 3'b110, 32'h7F800000, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 8'd1,   -8'sd1, 24'h800000, 3'b000, 32'h80000000, 1'b0, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 8'd1,   8'sd0,  24'h800001, 3'b011, 32'h00800001, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 8'd200, -8'sd3, 24'hC00000, 3'b110, 32'h62C00001, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 8'd130, 8'sd0,  24'h800003, 3'b100, 32'h41000004, 1'b0, 1'b0, 1'b1};

        bp[0] = '{1'b0, 8'd127, 8'sd0, 24'h800000, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0};
        bp[1] = '{1'b1, 8'd130, 8'sd1, 24'hABCDEF, 3'b101, 32'h0, 1'b0, 1'b0, 1'b0};
        bp[2] = '{1'b0, 8'd5,   -8'sd7,24'h912345, 3'b100, 32'h0, 1'b0, 1'b0, 1'b0};
        bp[3] = '{1'b0, 8'd200, 8'sd0, 24'hFFFFFF, 3'b111, 32'h0, 1'b0, 1'b0, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sign_in   = 1'b0;
        exp_in    = 8'd0;
        incr      = 8'sd0;
        mant_in   = 24'd0;
        grs_in    = 3'd0;
        #23 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.result",    64'(result),    64'd0);
        chk("rst.flags",     64'({overflow, underflow, inexact}), 64'd0);
        chk("rst.in_ready",  64'(in_ready),  64'd1);

        // Directed table
        for (int i = 0; i < 11; i++)
            apply_vec(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: four back-to-back items, output stalled three cycles
        @(posedge clk); #1;
        mon_en    = 1'b1;
        out_ready = 1'b0;
        idx       = 0;
        stall     = 0;
        base      = n_pop;
        e0        = ref_model(bp[0].sign, bp[0].exp, bp[0].inc, bp[0].mant, bp[0].grs);
        for (int c = 0; c < 40 && (n_pop - base) < 4; c++) begin
            @(posedge clk); #1;
            if (stall >= 3) out_ready = 1'b1;
            if (idx < 4) begin
                drive(bp[idx]);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            if (out_valid && !out_ready) begin
                chk("bp.stall_result", 64'(result), 64'(e0[34:3]));
                chk("bp.stall_in_ready", 64'(in_ready), 64'd0);
                stall++;
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp.accepted", 64'(idx), 64'd4);
        chk("bp.emitted",  64'(n_pop - base), 64'd4);
        chk("bp.stalls",   64'(stall), 64'd3);
        mon_en = 1'b0;

        // Asynchronous reset with two items in flight
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(vecs[1]);
        in_valid = 1'b1;
        @(posedge clk); #1;
        drive(vecs[3]);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("arst.pre_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.out_valid", 64'(out_valid), 64'd0);
        chk("arst.result",    64'(result),    64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst.flags", 64'({overflow, underflow, inexact}), 64'd0);
        exp_q.delete();
        apply_vec(vecs[9], "arst.after");

        // Randomized stream against the model
        @(posedge clk); #1;
        base   = n_pop;
        mon_en = 1'b1;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rv.sign   = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       rv.exp = 8'($urandom_range(0, 255));
                1:       rv.exp = 8'($urandom_range(245, 255));
                2:       rv.exp = 8'($urandom_range(0, 26));
                default: rv.exp = 8'($urandom_range(100, 150));
            endcase
            t       = int'($urandom_range(0, 25));
            rv.inc  = 8'(t - 24);
            rv.mant = ($urandom_range(0, 7) == 0) ? 24'd0 : {1'b1, 23'($urandom())};
            if ($urandom_range(0, 7) == 0) rv.mant = {1'b1, 23'h7FFFFF};
            rv.grs  = 3'($urandom_range(0, 7));
            drive(rv);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() != 0; c++)
            @(posedge clk);
        @(negedge clk);
        chk("rand.drain_empty", 64'(exp_q.size()), 64'd0);
        if ((n_pop - base) < 100)
            chk("rand.enough_items", 64'(n_pop - base), 64'd100);
        mon_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
